// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / restoring divide unit producing a 64-bit HI/LO result.
// Latency: 34 cycles from accept to oDone for MUL/DIV; 1 cycle for divide-by-zero.
// Backpressure: oBusy high while working; iStart ignored until the unit returns to IDLE.

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif
`ifndef ALU_INT_ADD
`define ALU_INT_ADD 5'd0
`endif
`ifndef ALU_INT_MUL
`define ALU_INT_MUL 5'd10
`endif
`ifndef ALU_INT_DIV
`define ALU_INT_DIV 5'd11
`endif

module mul_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = `ALU_OP_WIDTH
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  iStart,
    input  logic [OP_WIDTH-1:0]   iALUOperation,
    input  logic                  iSign,
    input  logic [DATA_WIDTH-1:0] iOperandA,
    input  logic [DATA_WIDTH-1:0] iOperandB,
    input  logic                  iFlush,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [DATA_WIDTH-1:0] oHi,
    output logic [DATA_WIDTH-1:0] oLo,
    output logic                  oDivByZero
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Latched operation context
    logic                    op_div;
    logic                    res_neg;   // MSB(A) ^ MSB(B) for signed ops
    logic                    rem_neg;   // remainder follows the dividend sign
    logic [DATA_WIDTH-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
    logic [2*DATA_WIDTH-1:0] acc;       // {hi, lo}: product or {remainder, quotient}
    logic [CW-1:0]           cnt;

    // Operand classification at the accept point
    logic is_mul, is_div, accept, div_zero;
    logic [DATA_WIDTH-1:0] mag_a, mag_b;

    assign is_mul   = (iALUOperation == `ALU_INT_MUL);
    assign is_div   = (iALUOperation == `ALU_INT_DIV);
    assign accept   = (state == IDLE) && iStart && !iFlush && (is_mul || is_div);
    assign div_zero = is_div && (iOperandB == '0);
    assign mag_a    = (iSign && iOperandA[DATA_WIDTH-1]) ? (~iOperandA + 1'b1) : iOperandA;
    assign mag_b    = (iSign && iOperandB[DATA_WIDTH-1]) ? (~iOperandB + 1'b1) : iOperandB;

    // One iteration of each algorithm, selected by op_div
    logic [DATA_WIDTH:0]     mul_sum;
    logic [2*DATA_WIDTH-1:0] mul_next;
    logic [DATA_WIDTH:0]     div_sh;
    logic [DATA_WIDTH+1:0]   div_diff;
    logic [2*DATA_WIDTH-1:0] div_next;

    // Shift-add step: conditionally add the multiplicand into the high half, then shift right
    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[DATA_WIDTH-1:1]};
    end

    // Restoring step: shift next dividend bit into the remainder and trial-subtract
    always_comb begin
        div_sh   = {acc[2*DATA_WIDTH-1:DATA_WIDTH], acc[DATA_WIDTH-1]};
        div_diff = {1'b0, div_sh} - {2'b00, opnd};
        if (div_diff[DATA_WIDTH+1])
            div_next = {div_sh[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
    end

    // Final sign correction applied in FIXUP
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   quot_fix, rem_fix;

    // Negate product, quotient and remainder according to latched sign flags
    always_comb begin
        prod_fix = res_neg ? (~acc + 1'b1) : acc;
        quot_fix = res_neg ? (~acc[DATA_WIDTH-1:0] + 1'b1) : acc[DATA_WIDTH-1:0];
        rem_fix  = rem_neg ? (~acc[2*DATA_WIDTH-1:DATA_WIDTH] + 1'b1)
                           : acc[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    // State register
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic; flush aborts only work that has not yet committed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = div_zero ? DONE : CALC;
            CALC:  if (iFlush) state_nxt = IDLE;
                   else if (cnt == LAST_ITER) state_nxt = FIXUP;
            FIXUP: state_nxt = iFlush ? IDLE : DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign oBusy = (state != IDLE);
    assign oDone = (state == DONE);

    // Datapath: latch on accept, iterate in CALC, commit on the edge entering DONE
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            op_div     <= 1'b0;
            res_neg    <= 1'b0;
            rem_neg    <= 1'b0;
            opnd       <= '0;
            acc        <= '0;
            cnt        <= '0;
            oHi        <= '0;
            oLo        <= '0;
            oDivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_div  <= is_div;
                        res_neg <= iSign && (iOperandA[DATA_WIDTH-1] ^ iOperandB[DATA_WIDTH-1]);
                        rem_neg <= iSign && iOperandA[DATA_WIDTH-1];
                        cnt     <= '0;
                        if (is_mul) begin
                            opnd <= mag_a;
                            acc  <= {{DATA_WIDTH{1'b0}}, mag_b};
                        end else begin
                            opnd <= mag_b;
                            acc  <= {{DATA_WIDTH{1'b0}}, mag_a};
                        end
                        if (div_zero) begin
                            oLo        <= '1;
                            oHi        <= iOperandA;
                            oDivByZero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    acc <= op_div ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                end
                FIXUP: begin
                    if (!iFlush) begin
                        oDivByZero <= 1'b0;
                        if (op_div) begin
                            oLo <= quot_fix;
                            oHi <= rem_fix;
                        end else begin
                            oLo <= prod_fix[DATA_WIDTH-1:0];
                            oHi <= prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Latency: checks exact accept-to-done edge counts.
// Backpressure: exercises iStart while busy, flush and async reset.

`timescale 1ns/1ps

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif
`ifndef ALU_INT_ADD
`define ALU_INT_ADD 5'd0
`endif
`ifndef ALU_INT_MUL
`define ALU_INT_MUL 5'd10
`endif
`ifndef ALU_INT_DIV
`define ALU_INT_DIV 5'd11
`endif

module tb_mul_div_unit;

    logic                     iClk = 1'b0;
    logic                     iReset_n = 1'b0;
    logic                     iStart = 1'b0;
    logic [`ALU_OP_WIDTH-1:0] iALUOperation = '0;
    logic                     iSign = 1'b0;
    logic [31:0]              iOperandA = '0;
    logic [31:0]              iOperandB = '0;
    logic                     iFlush = 1'b0;
    logic                     oBusy, oDone, oDivByZero;
    logic [31:0]              oHi, oLo;

    int checks = 0;
    int failures = 0;

    mul_div_unit dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iStart        (iStart),
        .iALUOperation (iALUOperation),
        .iSign         (iSign),
        .iOperandA     (iOperandA),
        .iOperandB     (iOperandB),
        .iFlush        (iFlush),
        .oBusy         (oBusy),
        .oDone         (oDone),
        .oHi           (oHi),
        .oLo           (oLo),
        .oDivByZero    (oDivByZero)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present an op for one edge, then wait for oDone (bounded).
    // edges = rising edges from accept (inclusive) to the cycle oDone is seen.
    // busy_ok = oBusy stayed high on every sampled cycle before oDone.
    task automatic run_op(input logic [`ALU_OP_WIDTH-1:0] op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          output int edges, output logic busy_ok);
        iALUOperation = op;
        iSign         = sgn;
        iOperandA     = a;
        iOperandB     = b;
        iStart        = 1'b1;
        @(posedge iClk); #1;
        iStart  = 1'b0;
        edges   = 1;
        busy_ok = 1'b1;
        while (!oDone && edges < 100) begin
            if (!oBusy) busy_ok = 1'b0;
            @(posedge iClk); #1;
            edges++;
        end
        // Return to IDLE before the next request
        @(posedge iClk); #1;
    endtask

    int   n;
    logic bok;
    int   done_seen;

    initial begin
        #23;
        check("rst_busy", 64'(oBusy), 64'd0);
        check("rst_done", 64'(oDone), 64'd0);
        check("rst_hi",   64'(oHi), 64'd0);
        check("rst_lo",   64'(oLo), 64'd0);
        check("rst_dbz",  64'(oDivByZero), 64'd0);
        iReset_n = 1'b1;
        @(posedge iClk); #1;

        // Unsigned max * max, with latency and one-cycle done pulse
        run_op(`ALU_INT_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, bok);
        check("umul_lat",  64'(n), 64'd34);
        check("umul_busy", 64'(bok), 64'd1);
        check("umul_hi",   64'(oHi), 64'hFFFF_FFFE);
        check("umul_lo",   64'(oLo), 64'h0000_0001);
        check("umul_dbz",  64'(oDivByZero), 64'd0);
        check("done_pulse", 64'(oDone), 64'd0);

        run_op(`ALU_INT_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7, n, bok);
        check("smul_hi", 64'(oHi), 64'hFFFF_FFFF);
        check("smul_lo", 64'(oLo), 64'hFFFF_FFEB);

        run_op(`ALU_INT_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, n, bok);
        check("sdiv_lat", 64'(n), 64'd34);
        check("sdiv_lo",  64'(oLo), 64'hFFFF_FFFD);
        check("sdiv_hi",  64'(oHi), 64'hFFFF_FFFF);

        run_op(`ALU_INT_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, n, bok);
        check("ovf_lo",  64'(oLo), 64'h8000_0000);
        check("ovf_hi",  64'(oHi), 64'd0);
        check("ovf_dbz", 64'(oDivByZero), 64'd0);

        run_op(`ALU_INT_DIV, 1'b0, 32'd100, 32'd7, n, bok);
        check("udiv_lo", 64'(oLo), 64'd14);
        check("udiv_hi", 64'(oHi), 64'd2);

        run_op(`ALU_INT_DIV, 1'b0, 32'h1234_5678, 32'd0, n, bok);
        check("dbz_lat", 64'(n), 64'd1);
        check("dbz_lo",  64'(oLo), 64'hFFFF_FFFF);
        check("dbz_hi",  64'(oHi), 64'h1234_5678);
        check("dbz_flag", 64'(oDivByZero), 64'd1);

        run_op(`ALU_INT_MUL, 1'b0, 32'd2, 32'd3, n, bok);
        check("mul23_lo",  64'(oLo), 64'd6);
        check("mul23_hi",  64'(oHi), 64'd0);
        check("mul23_dbz", 64'(oDivByZero), 64'd0);

        // Flush at CALC iteration 10
        iALUOperation = `ALU_INT_MUL; iSign = 1'b0;
        iOperandA = 32'd1000; iOperandB = 32'd1000; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        repeat (10) begin @(posedge iClk); #1; end
        iFlush = 1'b1;
        @(posedge iClk); #1;
        iFlush = 1'b0;
        check("flush_busy", 64'(oBusy), 64'd0);
        check("flush_done", 64'(oDone), 64'd0);
        check("flush_lo",   64'(oLo), 64'd6);
        check("flush_hi",   64'(oHi), 64'd0);
        done_seen = 0;
        repeat (40) begin @(posedge iClk); #1; if (oDone) done_seen++; end
        check("flush_nodone", 64'(done_seen), 64'd0);

        // Flush in IDLE blocks acceptance
        iALUOperation = `ALU_INT_MUL; iStart = 1'b1; iFlush = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0; iFlush = 1'b0;
        check("idle_flush_busy", 64'(oBusy), 64'd0);

        // Unsupported op is ignored
        iALUOperation = `ALU_INT_ADD; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        check("add_busy", 64'(oBusy), 64'd0);
        @(posedge iClk); #1;
        check("add_busy2", 64'(oBusy), 64'd0);

        // iStart while busy is ignored; the original MUL completes unchanged
        iALUOperation = `ALU_INT_MUL; iSign = 1'b0;
        iOperandA = 32'd9; iOperandB = 32'd4; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        repeat (5) begin @(posedge iClk); #1; end
        iALUOperation = `ALU_INT_DIV; iOperandA = 32'd100; iOperandB = 32'd7; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        n = 7;
        while (!oDone && n < 100) begin @(posedge iClk); #1; n++; end
        check("busy_ign_lat", 64'(n), 64'd34);
        check("busy_ign_lo",  64'(oLo), 64'd36);
        check("busy_ign_hi",  64'(oHi), 64'd0);
        @(posedge iClk); #1;
        check("busy_ign_idle", 64'(oBusy), 64'd0);

        // Asynchronous reset mid-CALC
        iALUOperation = `ALU_INT_MUL; iOperandA = 32'd123; iOperandB = 32'd456; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        repeat (5) begin @(posedge iClk); #1; end
        #2;
        iReset_n = 1'b0;
        #1;
        check("arst_busy", 64'(oBusy), 64'd0);
        check("arst_lo",   64'(oLo), 64'd0);
        check("arst_hi",   64'(oHi), 64'd0);
        check("arst_done", 64'(oDone), 64'd0);
        #7;
        iReset_n = 1'b1;
        done_seen = 0;
        repeat (40) begin @(posedge iClk); #1; if (oDone) done_seen++; end
        check("arst_nodone", 64'(done_seen), 64'd0);

        run_op(`ALU_INT_MUL, 1'b0, 32'd5, 32'd5, n, bok);
        check("post_rst_lo", 64'(oLo), 64'd25);
        check("post_rst_hi", 64'(oHi), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative integer multiply/divide execution unit, directly downstream of the ALU operation decoder.
- Consumes the decoded ALU operation code and signedness flag, together with two register operands.
- Produces a 64-bit result as HI/LO registers.
- Handles only `ALU_INT_MUL and `ALU_INT_DIV; all other operation codes are rejected. Single-cycle integer and FP ops are executed elsewhere.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width
- OP_WIDTH, `ALU_OP_WIDTH, width of the ALU operation code

Ports:
- iClk  input  1  clock; all state updates on rising edge
- iReset_n  input  1  asynchronous active-low reset
- iStart  input  1  request to start an operation this cycle
- iALUOperation  input  OP_WIDTH  decoded ALU operation code
- iSign  input  1  1 = signed operands, 0 = unsigned
- iOperandA  input  DATA_WIDTH  multiplicand / dividend
- iOperandB  input  DATA_WIDTH  multiplier / divisor
- iFlush  input  1  synchronous abort of any in-flight operation
- oBusy  output  1  high whenever state is not IDLE
- oDone  output  1  one-cycle pulse; HI/LO/oDivByZero valid and committed
- oHi  output  DATA_WIDTH  product high word / remainder
- oLo  output  DATA_WIDTH  product low word / quotient
- oDivByZero  output  1  last completed DIV had a zero divisor

Behaviour:
- Reset (iReset_n low, asynchronous):
  - state = IDLE.
  - oBusy, oDone, oDivByZero = 0; oHi, oLo = 0.
  - Counter and internal datapath registers cleared.
  - Reset mid-operation discards the operation immediately; no oDone follows.
- States: IDLE, CALC, FIXUP, DONE.
- Acceptance:
  - Condition: state IDLE, iStart = 1, iFlush = 0, iALUOperation is `ALU_INT_MUL or `ALU_INT_DIV.
  - Operands, op and sign are latched on that edge.
  - Any other op code with iStart is ignored; unit stays IDLE.
  - iStart is ignored while oBusy = 1.
- Sign handling when iSign = 1:
  - Operands are converted to magnitudes before iteration.
  - Result sign flag = MSB(A) XOR MSB(B).
  - Remainder takes the sign of the dividend.
  - When iSign = 0, no conversion is done.
- MUL:
  - IDLE -> CALC; 32 shift-add iterations, one per cycle, counter 0..31.
  - CALC -> FIXUP after iteration 31. FIXUP negates the 64-bit product if the result sign flag is set.
  - {oHi,oLo} = product.
- DIV, divisor != 0:
  - IDLE -> CALC; 32 restoring-division iterations, one per cycle.
  - FIXUP negates the quotient and/or remainder per the sign rules.
  - oLo = quotient, oHi = remainder.
  - Signed -2^31 / -1 gives oLo = 0x80000000, oHi = 0 (natural magnitude result; no trap).
- DIV, divisor = 0:
  - IDLE -> DONE directly.
  - oLo = all ones, oHi = dividend as presented, oDivByZero = 1.
- Latency:
  - MUL/DIV: oDone high in the cycle following the 34th rising edge after acceptance (1 accept + 32 CALC + 1 FIXUP).
  - DIV by zero: oDone high in the cycle following the acceptance edge.
- Commit timing:
  - oHi, oLo and oDivByZero are written on the edge entering DONE and held until the next edge entering DONE.
  - oDivByZero = 0 for every completion other than divide-by-zero.
- DONE lasts exactly one cycle (oDone = 1), then returns to IDLE. A new iStart is accepted no earlier than the cycle after DONE.
- iFlush:
  - In CALC or FIXUP: next state IDLE, no oDone, oHi/oLo/oDivByZero retain prior values.
  - In DONE: no effect; the result is already committed.
  - In IDLE: blocks acceptance, even with iStart asserted.
- Arithmetic:
  - All internal magnitudes are DATA_WIDTH-bit unsigned; the partial product is 2*DATA_WIDTH bits.
  - Magnitude of -2^31 is 0x80000000 (no overflow in unsigned form).

Test Plan:
- Unsigned MUL, A = 0xFFFFFFFF, B = 0xFFFFFFFF -> oDone exactly 34 cycles after accept, oHi = 0xFFFFFFFE, oLo = 0x00000001, oBusy high throughout.
- Signed MUL, -3 * 7 -> oHi = 0xFFFFFFFF, oLo = 0xFFFFFFEB. Signed DIV, -7 / 2 -> oLo = 0xFFFFFFFD, oHi = 0xFFFFFFFF.
- Signed DIV, 0x80000000 / 0xFFFFFFFF -> oLo = 0x80000000, oHi = 0, oDivByZero = 0. Unsigned DIV, 100 / 7 -> oLo = 14, oHi = 2.
- DIV, A = 0x12345678, B = 0 -> oDone the cycle after accept, oLo = 0xFFFFFFFF, oHi = 0x12345678, oDivByZero = 1; a following MUL 2*3 clears oDivByZero.
- iFlush at CALC iteration 10 -> IDLE next cycle, no oDone, oHi/oLo unchanged. iStart with op `ALU_INT_ADD -> ignored, oBusy stays 0. iStart during busy -> ignored.
- iReset_n pulsed low mid-CALC, asynchronous to iClk -> all outputs 0 immediately, no oDone after release, next MUL 5*5 gives oLo = 25.
